// File: rtl/sram_img_proc_ctrl.sv
// Image SRAM pass sequencer: reads NUM_PIX source words, applies the selected pixel op,
// writes each result to the destination region, then pulses store and reports done.
module sram_img_proc_ctrl #(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 16,
  parameter int NUM_PIX  = 262144,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 262144
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] operand,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              sram_csn,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout,
  output logic              sram_store
);
  // state | meaning
  // IDLE  | waiting for start
  // RD    | read source word SRC_BASE+idx
  // LAT   | read data returns; pix <= f(sram_dout)
  // WR    | write pix to DST_BASE+idx
  // STORE | one-cycle SRAM dump strobe
  // DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_LAT, S_WR, S_STORE, S_DONE
  } state_t;

  localparam int IDX_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam logic [ADDR_W-1:0] SRC_A   = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] DST_A   = ADDR_W'(DST_BASE);
  localparam logic [IDX_W-1:0]  IDX_END = IDX_W'(NUM_PIX - 1);

  state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_pix;
  logic [1:0]          r_mode;
  logic [DATA_W-1:0]   r_operand;
  logic                r_aborted;
  logic                w_accept;
  logic                w_last;
  logic [ADDR_W-1:0]   w_idx_a;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W-1:0]   w_pix_nxt;

  assign w_last  = (r_idx == IDX_END);
  assign w_idx_a = ADDR_W'(r_idx);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_pix     <= '0;
      r_mode    <= '0;
      r_operand <= '0;
      r_aborted <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_idx     <= '0;
        r_mode    <= mode;
        r_operand <= operand;
      end else if (r_state == S_WR && !w_last && !abort) begin
        r_idx <= r_idx + 1'b1;
      end
      if (r_state == S_LAT) r_pix <= w_pix_nxt;
      if (abort)         r_aborted <= 1'b1;
      else if (w_accept) r_aborted <= 1'b0;
    end
  end

  // Saturating add keeps the carry in the extra top bit.
  always_comb begin
    w_sum     = {1'b0, sram_dout} + {1'b0, r_operand};
    w_pix_nxt = sram_dout;
    case (r_mode)
      2'b00:   w_pix_nxt = sram_dout;
      2'b01:   w_pix_nxt = ~sram_dout;
      2'b10:   w_pix_nxt = (sram_dout >= r_operand) ? '1 : '0;
      default: w_pix_nxt = w_sum[DATA_W] ? '1 : w_sum[DATA_W-1:0];
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_state_nxt = S_RD;
          w_accept    = 1'b1;
        end
      end
      S_RD:    w_state_nxt = S_LAT;
      S_LAT:   w_state_nxt = S_WR;
      S_WR:    w_state_nxt = w_last ? S_STORE : S_RD;
      S_STORE: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort && r_state != S_IDLE) w_state_nxt = S_IDLE;
  end

  always_comb begin
    sram_csn   = 1'b1;
    sram_wen   = 1'b0;
    sram_a     = '0;
    sram_store = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_RD: begin
        sram_csn = 1'b0;
        sram_a   = SRC_A + w_idx_a;
        busy     = 1'b1;
      end
      S_LAT: busy = 1'b1;
      S_WR: begin
        sram_csn = 1'b0;
        sram_wen = 1'b1;
        sram_a   = DST_A + w_idx_a;
        busy     = 1'b1;
      end
      S_STORE: begin
        sram_store = 1'b1;
        busy       = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign sram_din = r_pix;
  assign aborted  = r_aborted;

endmodule

// File: tb/tb_sram_img_proc_ctrl.sv
// Bench for sram_img_proc_ctrl: two instances (separate and in-place regions) on small
// behavioural SRAMs, table vectors, hand-written abort/reset sequences and random passes.
module tb_sram_img_proc_ctrl;
  localparam int AW = 5;
  localparam int DW = 16;
  localparam int NP = 4;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  logic          start_s [2];
  logic          abort_s [2];
  logic [1:0]    mode_s  [2];
  logic [DW-1:0] op_s    [2];
  logic          busy_s  [2];
  logic          done_s  [2];
  logic          abrt_s  [2];
  logic          csn_s   [2];
  logic          wen_s   [2];
  logic [AW-1:0] a_s     [2];
  logic [DW-1:0] din_s   [2];
  logic [DW-1:0] dout_s  [2];
  logic          store_s [2];
  logic [DW-1:0] mem [2][32];
  int            store_cnt [2];
  int            wr_cnt    [2];

  logic          ld_en   = 1'b0;
  int            ld_sel  = 0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;

  int checks   = 0;
  int failures = 0;

  sram_img_proc_ctrl #(.ADDR_W(AW), .DATA_W(DW), .NUM_PIX(NP), .SRC_BASE(0), .DST_BASE(8)) u_dut (
    .clk(clk), .rstn(rstn), .start(start_s[0]), .abort(abort_s[0]), .mode(mode_s[0]),
    .operand(op_s[0]), .busy(busy_s[0]), .done(done_s[0]), .aborted(abrt_s[0]),
    .sram_csn(csn_s[0]), .sram_wen(wen_s[0]), .sram_a(a_s[0]), .sram_din(din_s[0]),
    .sram_dout(dout_s[0]), .sram_store(store_s[0]));

  sram_img_proc_ctrl #(.ADDR_W(AW), .DATA_W(DW), .NUM_PIX(NP), .SRC_BASE(0), .DST_BASE(0)) u_inp (
    .clk(clk), .rstn(rstn), .start(start_s[1]), .abort(abort_s[1]), .mode(mode_s[1]),
    .operand(op_s[1]), .busy(busy_s[1]), .done(done_s[1]), .aborted(abrt_s[1]),
    .sram_csn(csn_s[1]), .sram_wen(wen_s[1]), .sram_a(a_s[1]), .sram_din(din_s[1]),
    .sram_dout(dout_s[1]), .sram_store(store_s[1]));

  // Synchronous SRAM: read data appears the cycle after the read cycle.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!csn_s[g]) begin
        if (wen_s[g]) mem[g][a_s[g]] <= din_s[g];
        else          dout_s[g]      <= mem[g][a_s[g]];
      end
      if (store_s[g])           store_cnt[g] <= store_cnt[g] + 1;
      if (!csn_s[g] && wen_s[g]) wr_cnt[g]   <= wr_cnt[g] + 1;
    end
    if (ld_en) mem[ld_sel][ld_addr] <= ld_data;
  end

  function automatic logic [15:0] ref_f(input logic [1:0] m, input logic [15:0] op,
                                        input logic [15:0] d);
    int s;
    case (m)
      2'd0: return d;
      2'd1: return 16'(65535 - int'(d));
      2'd2: return (int'(d) >= int'(op)) ? 16'hFFFF : 16'h0000;
      default: begin
        s = int'(d) + int'(op);
        return (s > 65535) ? 16'hFFFF : 16'(s);
      end
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic poke(input int s, input int addr, input logic [15:0] d);
    ld_sel = s; ld_addr = AW'(addr); ld_data = d; ld_en = 1'b1;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic chk_idle_outputs(input int s, input string nm);
    chk($sformatf("%s csn", nm), 32'(csn_s[s]), 1);
    chk($sformatf("%s wen", nm), 32'(wen_s[s]), 0);
    chk($sformatf("%s a", nm), 32'(a_s[s]), 0);
    chk($sformatf("%s din", nm), 32'(din_s[s]), 0);
    chk($sformatf("%s store", nm), 32'(store_s[s]), 0);
    chk($sformatf("%s busy", nm), 32'(busy_s[s]), 0);
    chk($sformatf("%s done", nm), 32'(done_s[s]), 0);
    chk($sformatf("%s aborted", nm), 32'(abrt_s[s]), 0);
  endtask

  task automatic run_pass(input int s, input logic [1:0] m, input logic [15:0] op,
                          input logic [3:0][15:0] px, input logic [3:0][15:0] ex,
                          input bit extra, input string nm);
    int cyc, st0, wr0, dst;
    dst = (s == 0) ? 8 : 0;
    for (int i = 0; i < NP; i++) poke(s, i, px[i]);
    if (s == 0) for (int i = 0; i < NP; i++) poke(s, 8 + i, 16'hDEAD);
    st0 = store_cnt[s];
    wr0 = wr_cnt[s];
    start_s[s] = 1'b1; mode_s[s] = m; op_s[s] = op;
    @(posedge clk); #1;
    start_s[s] = 1'b0; mode_s[s] = ~m; op_s[s] = ~op;
    chk($sformatf("%s busy_after_accept", nm), 32'(busy_s[s]), 1);
    chk($sformatf("%s aborted_cleared", nm), 32'(abrt_s[s]), 0);
    cyc = 1;
    while (!done_s[s] && cyc < 60) begin
      start_s[s] = (extra && cyc == 5);
      @(posedge clk); #1;
      cyc++;
    end
    start_s[s] = 1'b0;
    chk($sformatf("%s done_latency", nm), 32'(cyc), 3 * NP + 2);
    chk($sformatf("%s busy_at_done", nm), 32'(busy_s[s]), 0);
    chk($sformatf("%s store_pulses", nm), 32'(store_cnt[s] - st0), 1);
    chk($sformatf("%s write_count", nm), 32'(wr_cnt[s] - wr0), NP);
    for (int i = 0; i < NP; i++)
      chk($sformatf("%s mem[%0d]", nm, dst + i), 32'(mem[s][dst + i]), 32'(ex[i]));
    @(posedge clk); #1;
    chk($sformatf("%s done_one_cycle", nm), 32'(done_s[s]), 0);
  endtask

  typedef struct packed {
    logic             sel;
    logic             extra;
    logic [1:0]       m;
    logic [15:0]      op;
    logic [3:0][15:0] px;
    logic [3:0][15:0] ex;
  } vec_t;

  vec_t vt [5];

  initial begin
    int st0, wr0, dn;
    logic [1:0]       rm;
    logic [15:0]      rop;
    logic [3:0][15:0] rp, re;

    vt[0] = '{sel: 1'b0, extra: 1'b0, m: 2'd0, op: 16'h0000,
              px: {16'h0004, 16'h0003, 16'h0002, 16'h0001},
              ex: {16'h0004, 16'h0003, 16'h0002, 16'h0001}};
    vt[1] = '{sel: 1'b0, extra: 1'b0, m: 2'd1, op: 16'h0000,
              px: {16'hFFFF, 16'h0000, 16'h1234, 16'h00FF},
              ex: {16'h0000, 16'hFFFF, 16'hEDCB, 16'hFF00}};
    vt[2] = '{sel: 1'b0, extra: 1'b0, m: 2'd2, op: 16'h0080,
              px: {16'h0000, 16'h0081, 16'h0080, 16'h007F},
              ex: {16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000}};
    vt[3] = '{sel: 1'b0, extra: 1'b0, m: 2'd3, op: 16'h0010,
              px: {16'h7FFF, 16'hFFEF, 16'h0001, 16'hFFF8},
              ex: {16'h800F, 16'hFFFF, 16'h0011, 16'hFFFF}};
    vt[4] = '{sel: 1'b1, extra: 1'b1, m: 2'd1, op: 16'h5555,
              px: {16'hFFFF, 16'h0000, 16'h1234, 16'h00FF},
              ex: {16'h0000, 16'hFFFF, 16'hEDCB, 16'hFF00}};

    for (int s = 0; s < 2; s++) begin
      start_s[s] = 1'b0; abort_s[s] = 1'b0; mode_s[s] = 2'd0; op_s[s] = '0;
    end

    #2 rstn = 1'b0;
    #1;
    chk_idle_outputs(0, "reset_dut");
    chk_idle_outputs(1, "reset_inp");
    repeat (3) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++)
      run_pass(int'(vt[i].sel), vt[i].m, vt[i].op, vt[i].px, vt[i].ex, vt[i].extra,
               $sformatf("vec%0d", i));

    // Abort during LAT of pixel 2: pixels 0..1 written, the rest untouched.
    for (int i = 0; i < NP; i++) poke(0, i, 16'(i + 1));
    for (int i = 0; i < NP; i++) poke(0, 8 + i, 16'hDEAD);
    st0 = store_cnt[0]; wr0 = wr_cnt[0];
    start_s[0] = 1'b1; mode_s[0] = 2'd0;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    abort_s[0] = 1'b1;
    @(posedge clk); #1;
    abort_s[0] = 1'b0;
    chk("abort busy", 32'(busy_s[0]), 0);
    chk("abort aborted", 32'(abrt_s[0]), 1);
    chk("abort csn", 32'(csn_s[0]), 1);
    dn = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done_s[0]) dn++;
    end
    chk("abort no_done", 32'(dn), 0);
    chk("abort no_store", 32'(store_cnt[0] - st0), 0);
    chk("abort writes", 32'(wr_cnt[0] - wr0), 2);
    chk("abort mem8", 32'(mem[0][8]), 32'h1);
    chk("abort mem9", 32'(mem[0][9]), 32'h2);
    chk("abort mem10", 32'(mem[0][10]), 32'hDEAD);
    chk("abort mem11", 32'(mem[0][11]), 32'hDEAD);
    chk("abort sticky", 32'(abrt_s[0]), 1);
    run_pass(0, 2'd0, 16'h0, vt[0].px, vt[0].ex, 1'b0, "after_abort");

    // Abort together with start in IDLE: start dropped.
    start_s[0] = 1'b1; abort_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0; abort_s[0] = 1'b0;
    chk("abort_start busy", 32'(busy_s[0]), 0);
    chk("abort_start aborted", 32'(abrt_s[0]), 1);
    @(posedge clk); #1;
    chk("abort_start still_idle", 32'(csn_s[0]), 1);

    // Asynchronous reset mid-pass.
    st0 = store_cnt[0];
    start_s[0] = 1'b1; mode_s[0] = 2'd1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rstn = 1'b0;
    #1;
    chk_idle_outputs(0, "midreset");
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    chk("midreset no_store", 32'(store_cnt[0] - st0), 0);
    chk("midreset idle", 32'(busy_s[0]), 0);

    // Random passes against the reference model.
    for (int r = 0; r < 10; r++) begin
      rm  = 2'($urandom_range(0, 3));
      for (int i = 0; i < NP; i++) rp[i] = 16'($urandom);
      rop = (r % 3 == 0) ? rp[$urandom_range(0, 3)] : 16'($urandom);
      for (int i = 0; i < NP; i++) re[i] = ref_f(rm, rop, rp[i]);
      run_pass(r % 2, rm, rop, rp, re, bit'(r % 2), $sformatf("rand%0d_m%0d", r, rm));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
